// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter. A queued byte launches one edge after it is visible in IDLE with tx_busy low.
// Producer backpressure is full/overflow. A launch that never sees tx_busy rise is dropped after BUSY_WAIT cycles and flagged with launch_err.
module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 8,
  parameter int BUSY_WAIT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     launch_err,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_transmit,
  input  logic                     tx_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [CW-1:0]     r_wait_cnt;
  logic              r_overflow;
  logic              r_launch_err;
  logic              r_tx_transmit;
  logic [DATA_W-1:0] r_tx_data;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_pop;
  logic w_timeout;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // A pop in the same cycle never frees room for a write; full is judged on the registered level.
  assign w_wr_ok   = wr_en & ~w_full & ~flush;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~tx_busy & ~flush;
  assign w_timeout = (r_state == S_WAIT_HI) & ~tx_busy & (r_wait_cnt == CW'(BUSY_WAIT - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_pop) w_next_state = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tx_busy)        w_next_state = S_WAIT_LO;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_WAIT_LO: if (!tx_busy) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr_ok, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_overflow    <= 1'b0;
      r_launch_err  <= 1'b0;
      r_tx_transmit <= 1'b0;
      r_tx_data     <= '0;
    end else begin
      r_overflow    <= wr_en & w_full & ~flush;
      r_launch_err  <= w_timeout;
      r_tx_transmit <= w_pop;
      if (w_pop) begin
        r_tx_data  <= r_mem[r_rd_ptr];
        r_wait_cnt <= '0;
      end else if ((r_state == S_WAIT_HI) && !tx_busy && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end
    end
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign launch_err  = r_launch_err;
  assign tx_transmit = r_tx_transmit;
  assign tx_data     = r_tx_data;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed plus randomized bench for uart_tx_feeder with a queue-based scoreboard and transmitter model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int BW    = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full, empty, overflow, launch_err, tx_transmit;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       tx_busy;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(8), .BUSY_WAIT(BW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .launch_err(launch_err), .tx_data(tx_data), .tx_transmit(tx_transmit),
    .tx_busy(tx_busy)
  );

  int  n_chk = 0, n_pass = 0, cyc = 0;
  int  n_pulse = 0, n_err = 0, n_ovf = 0;
  int  launch_cyc = 0, err_cyc = 0, xcnt = 0, busy_len = 50;
  bit  auto_tx = 0, rand_len = 0, prev_pulse = 0, seen_bad = 0;
  logic [7:0] bad_byte = 8'hFF;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample outputs, score launches against the expected byte order, run the transmitter model.
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_transmit === 1'b1) begin
      n_pulse++;
      launch_cyc = cyc;
      chk("no_back_to_back_pulse", int'(prev_pulse), 0);
      chk("launch_had_queued_byte", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tx_data_order", int'(tx_data), int'(e));
      end
      if (tx_data === bad_byte) seen_bad = 1;
    end
    prev_pulse = (tx_transmit === 1'b1);
    if (launch_err === 1'b1) begin
      n_err++;
      err_cyc = cyc;
    end
    if (overflow === 1'b1) n_ovf++;
    if (rst_n) chk("level_vs_model", int'(level), sb.size());
    if (auto_tx) begin
      if (tx_transmit === 1'b1) xcnt = rand_len ? int'($urandom_range(1, 8)) : busy_len;
      else if (xcnt > 0) xcnt--;
      tx_busy = (xcnt > 0);
    end
  endtask

  task automatic write(input logic [7:0] b, input bit fl);
    bit acc;
    wr_en   = 1'b1;
    wr_data = b;
    flush   = fl;
    acc = !fl && (sb.size() < DEPTH);
    if (fl) sb.delete();
    else if (acc) sb.push_back(b);
    step();
    chk("overflow_pulse", int'(overflow), int'(!fl && !acc));
    wr_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    int p0, e0, o0, k;
    logic [7:0] b0, b1;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; tx_busy = 1'b0;
    step();
    step();
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_tx_transmit", int'(tx_transmit), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_launch_err", int'(launch_err), 0);
    rst_n = 1'b1;
    step();

    // Single byte: launch one edge after the write, data held through the frame.
    write(8'hA5, 0);
    chk("t1_level_after_write", int'(level), 1);
    chk("t1_no_launch_same_edge", int'(tx_transmit), 0);
    step();
    chk("t1_launch_next_edge", int'(tx_transmit), 1);
    chk("t1_tx_data", int'(tx_data), 8'hA5);
    chk("t1_empty_again", int'(empty), 1);
    step();
    chk("t1_pulse_one_cycle", int'(tx_transmit), 0);
    step();
    tx_busy = 1'b1;
    repeat (20) step();
    tx_busy = 1'b0;
    repeat (4) step();
    chk("t1_pulse_count", n_pulse, 1);
    chk("t1_no_launch_err", n_err, 0);
    chk("t1_tx_data_held", int'(tx_data), 8'hA5);

    // Fill while the transmitter is stuck busy, then one dropped write.
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(i), 0);
    chk("t2_full", int'(full), 1);
    chk("t2_level16", int'(level), 16);
    chk("t2_not_empty", int'(empty), 0);
    bad_byte = 8'hFF;
    seen_bad = 0;
    o0 = n_ovf;
    write(8'hFF, 0);
    step();
    chk("t2_overflow_one_cycle", int'(overflow), 0);
    chk("t2_overflow_count", n_ovf - o0, 1);
    chk("t2_level_kept", int'(level), 16);

    // Drain through a 50-cycle transmitter model.
    busy_len = 50; rand_len = 0; xcnt = 0; auto_tx = 1; tx_busy = 1'b0;
    p0 = n_pulse;
    k = 0;
    while (!((n_pulse - p0) == 16 && tx_busy == 1'b0) && k < 2000) begin
      step();
      k++;
    end
    chk("t3_drain_in_budget", int'(k < 2000), 1);
    repeat (3) step();
    chk("t3_pulses", n_pulse - p0, 16);
    chk("t3_empty", int'(empty), 1);
    chk("t3_ff_never_sent", int'(seen_bad), 0);
    chk("t3_no_err", n_err, 0);

    // Lost launches: tx_busy never rises.
    auto_tx = 0; tx_busy = 1'b0;
    b0 = 8'($urandom); b1 = 8'($urandom);
    e0 = n_err;
    write(b0, 0);
    write(b1, 0);
    k = 0;
    while (n_err == e0 && k < 40) begin step(); k++; end
    chk("t4_err_seen", n_err - e0, 1);
    chk("t4_err_delay", err_cyc - launch_cyc, BW);
    step();
    chk("t4_err_one_cycle", int'(launch_err), 0);
    chk("t4_next_launch", int'(tx_transmit), 1);
    chk("t4_next_data", int'(tx_data), int'(b1));
    k = 0;
    while (n_err == e0 + 1 && k < 40) begin step(); k++; end
    chk("t4_second_err", n_err - e0, 2);
    chk("t4_empty", int'(empty), 1);

    // Flush with a same-cycle write while a byte is in flight.
    write(8'h11, 0);
    step();
    chk("t5_launch", int'(tx_transmit), 1);
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 5; i++) write(8'($urandom), 0);
    chk("t5_level5", int'(level), 5);
    bad_byte = 8'h77; seen_bad = 0;
    p0 = n_pulse; o0 = n_ovf;
    write(8'h77, 1);
    chk("t5_level_flushed", int'(level), 0);
    chk("t5_empty_flushed", int'(empty), 1);
    step();
    chk("t5_no_overflow", n_ovf - o0, 0);
    tx_busy = 1'b0;
    repeat (6) step();
    chk("t5_no_new_launch", n_pulse - p0, 0);
    chk("t5_inflight_data_kept", int'(tx_data), 8'h11);
    chk("t5_77_never_sent", int'(seen_bad), 0);

    // Asynchronous reset in WAIT_LO with bytes queued.
    write(8'h22, 0);
    step();
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 3; i++) write(8'($urandom), 0);
    chk("t6_level3", int'(level), 3);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_async_empty", int'(empty), 1);
    chk("t6_async_full", int'(full), 0);
    chk("t6_async_level", int'(level), 0);
    chk("t6_async_tx_data", int'(tx_data), 0);
    chk("t6_async_tx_transmit", int'(tx_transmit), 0);
    chk("t6_async_overflow", int'(overflow), 0);
    chk("t6_async_launch_err", int'(launch_err), 0);
    step();
    tx_busy = 1'b0;
    rst_n = 1'b1;
    p0 = n_pulse;
    repeat (10) step();
    chk("t6_no_launch_after_reset", n_pulse - p0, 0);
    busy_len = 3; rand_len = 0; xcnt = 0; auto_tx = 1;
    write(8'h5A, 0);
    step();
    chk("t6_new_launch", int'(tx_transmit), 1);
    chk("t6_new_data", int'(tx_data), 8'h5A);
    repeat (10) step();

    // Random bursts against a transmitter with random frame lengths.
    rand_len = 1;
    e0 = n_err;
    repeat (60) begin
      repeat ($urandom_range(0, 3)) step();
      write(8'($urandom), 0);
    end
    k = 0;
    while (!(sb.size() == 0 && xcnt == 0) && k < 3000) begin step(); k++; end
    chk("rand_drain_in_budget", int'(k < 3000), 1);
    repeat (3) step();
    chk("rand_empty", int'(empty), 1);
    chk("rand_level0", int'(level), 0);
    chk("rand_no_err", n_err - e0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO plus launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer with a write-enable interface and buffers them.
- Presents each byte to the transmitter's data/transmit/busy interface, one frame at a time.
- Gives the producer back-pressure (full) and occupancy visibility, so software or a bench can burst bytes without polling tx busy.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- DATA_W, 8, byte width; must match the transmitter data port.
- BUSY_WAIT, 16, clk cycles to wait for tx_busy to rise after a launch before declaring the launch lost.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  producer write strobe; one byte per cycle.
- wr_data  input  DATA_W  byte to enqueue.
- flush  input  1  synchronous FIFO clear.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- launch_err  output  1  one-cycle pulse when BUSY_WAIT expires.
- tx_data  output  DATA_W  byte to transmitter data port.
- tx_transmit  output  1  one-cycle start pulse to transmitter.
- tx_busy  input  1  transmitter busy flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, level and wait counter cleared.
  - FSM in IDLE.
  - Outputs: empty=1, full=0, level=0, overflow=0, launch_err=0, tx_transmit=0, tx_data=0.
  - An in-flight byte is abandoned and FIFO contents are lost.
- FIFO storage: circular buffer.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is a separate counter.
  - full = (level==DEPTH); empty = (level==0); both derived from registered level.
- Write: accepted on a rising edge when wr_en=1, full=0 and flush=0.
  - Accepted: wr_data stored at the write pointer and the pointer increments.
  - wr_en=1 with full=1: byte dropped, contents unchanged, overflow=1 for the next cycle only.
  - A simultaneous pop in that cycle does not rescue the write.
- Pop: occurs only on the FSM IDLE->WAIT_HI transition.
- Simultaneous accepted write and pop: level unchanged, both pointers advance.
- Flush: on a rising edge with flush=1:
  - Pointers and level are zeroed.
  - Any same-cycle write is dropped without an overflow pulse.
  - The FSM and tx_data are not affected; a byte already launched completes normally.
- FSM states: IDLE, WAIT_HI, WAIT_LO.
  - IDLE: if empty=0 and tx_busy=0 (and no flush this cycle):
    - register tx_data <= head entry;
    - pop;
    - tx_transmit <= 1 for exactly one cycle;
    - clear the wait counter;
    - go to WAIT_HI.
  - IDLE otherwise: stay.
  - WAIT_HI: if tx_busy=1, go to WAIT_LO.
  - WAIT_HI timeout: otherwise increment the counter. When it reaches BUSY_WAIT-1 with tx_busy still 0:
    - pulse launch_err for one cycle;
    - go to IDLE;
    - the byte is considered consumed and is not retried.
  - WAIT_LO: when tx_busy=0, go to IDLE.
- tx_data holding: tx_data stays stable from a launch until the next launch, so the transmitter may sample it any time while busy.
- tx_transmit is never high in two consecutive cycles.
- Back-to-back launches are separated by at least one IDLE cycle after tx_busy falls.
- Latency: a byte written at edge N into an empty FIFO with tx_busy=0 and the FSM in IDLE:
  - tx_transmit is registered high at edge N+1;
  - empty returns to 1 at edge N+1 if no other writes occurred.
- tx_busy is assumed synchronous to clk. No synchroniser is included.

Test Plan:
- Reset then write 8'hA5 with tx_busy held 0 for 3 cycles after launch, then raised 20 cycles, then dropped -> exactly one tx_transmit pulse at edge N+1, tx_data=8'hA5, level returns 0, no launch_err.
- Write 16 bytes 8'h00..8'h0F back-to-back while tx_busy=1 stuck, then write 8'hFF -> full=1 after 16th write, level=16, overflow pulses once, 8'hFF never appears on tx_data.
- Release tx_busy and model a transmitter (busy high 50 cycles per launch) -> tx_data sequence 8'h00..8'h0F in order, 16 pulses, empty=1 at end.
- Launch with tx_busy never asserting -> launch_err pulses BUSY_WAIT cycles after launch, FSM returns to IDLE and launches the next queued byte.
- Fill 5 bytes, assert flush together with wr_en=1 (8'h77) during WAIT_LO -> level=0, no overflow, in-flight byte completes, 8'h77 never transmitted.
- Assert rst_n low asynchronously mid-WAIT_LO with 3 bytes queued -> all outputs at reset values immediately without a clock edge; after release, no tx_transmit until a new write.
